modinv_helper_double_precalc: RTL and testbench

Precalculation helper for the modular invertor's doubling step, the counterpart of the halving (reduce) precalc. It streams the multi-word buffer s and modulus q out of block memory, least significant word first. It writes two candidates: d = 2·s and e = 2·s − q. It also raises the selection flag sel_diff, which the invertor controller uses to copy either d or e back as 2·s mod q. The block sits beside the other modinv helpers, shares their memory ports and uses the same ena/rdy handshake.

---
 rtl/modinv_helper_double_precalc_pkg.sv | 48 ++++
 rtl/modinv_helper_double_precalc_sub.sv | 38 +++
 rtl/modinv_helper_double_precalc.sv | 133 +++++++++++++
 tb/tb_modinv_helper_double_precalc.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/modinv_helper_double_precalc_pkg.sv
// Shared constants and helpers for the modinv doubling precalc helper.
// Processing windows are expressed as counter values for an N-word buffer.
package modinv_helper_double_precalc_pkg;

   typedef logic [31:0] word_t;

   // First counter value of each phase
   localparam int RD_FIRST = 1;   // s/q read addresses
   localparam int D_FIRST  = 2;   // d write (shift path)
   localparam int E_FIRST  = 3;   // e write (registered subtractor)

   // Ceiling log2, at least 1 bit
   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      if (r == 0) r = 1;
      return r;
   endfunction

   // Full pass length including the idle count 0
   function automatic int proc_num_cycles(input int n);
      return n + 4;
   endfunction

   function automatic int rd_last(input int n);
      return n;
   endfunction

   function automatic int d_last(input int n);
      return n + 1;
   endfunction

   function automatic int e_last(input int n);
      return n + 2;
   endfunction

   // Count at which the final borrow is turned into sel_diff
   function automatic int flag_cnt(input int n);
      return n + 3;
   endfunction

endpackage

// File: rtl/modinv_helper_double_precalc_sub.sv
// Registered 32-bit subtract with borrow: d = a - b - b_in, b_out = borrow.
// Kept as its own wrapper so a vendor DSP primitive can replace it.
module subtractor32_wrapper
   import modinv_helper_double_precalc_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  word_t a,
   input  word_t b,
   input  logic  b_in,
   output word_t d,
   output logic  b_out
);

   logic [32:0] diff_next;
   word_t       d_reg;
   logic        b_out_reg;

   // 33-bit difference: bit 32 set means the word went negative
   always_comb begin
      diff_next = {1'b0, a} - {1'b0, b} - {32'd0, b_in};
   end

   // Output register for difference and borrow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_reg     <= '0;
         b_out_reg <= 1'b0;
      end else begin
         d_reg     <= diff_next[31:0];
         b_out_reg <= diff_next[32];
      end
   end

   assign d     = d_reg;
   assign b_out = b_out_reg;

endmodule

// File: rtl/modinv_helper_double_precalc.sv
// Doubling precalc: streams s and q (LSW first), writes d = 2*s and
// e = 2*s - q, and sets sel_diff when d >= q so the controller copies e.
module modinv_helper_double_precalc
   import modinv_helper_double_precalc_pkg::*;
#(
   parameter int OPERAND_NUM_WORDS = 8,
   parameter int OPERAND_ADDR_BITS = 3,
   parameter int BUFFER_NUM_WORDS  = 9,
   parameter int BUFFER_ADDR_BITS  = 4,
   parameter int K_NUM_BITS        = 10
)
(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         ena,
   output logic                         rdy,
   input  logic [K_NUM_BITS-1:0]        k,
   output logic                         k_is_nul,
   output logic                         sel_diff,
   output logic [BUFFER_ADDR_BITS-1:0]  s_addr,
   input  logic [31:0]                  s_din,
   output logic [OPERAND_ADDR_BITS-1:0] q_addr,
   input  logic [31:0]                  q_din,
   output logic [BUFFER_ADDR_BITS-1:0]  d_addr,
   output logic                         d_wren,
   output logic [31:0]                  d_dout,
   output logic [BUFFER_ADDR_BITS-1:0]  e_addr,
   output logic                         e_wren,
   output logic [31:0]                  e_dout
);

   localparam int CNT_BITS = clog2(proc_num_cycles(BUFFER_NUM_WORDS));
   typedef logic [CNT_BITS-1:0] cnt_t;

   localparam cnt_t CNT_ONE      = cnt_t'(1);
   localparam cnt_t CNT_RD_FIRST = cnt_t'(RD_FIRST);
   localparam cnt_t CNT_RD_LAST  = cnt_t'(rd_last(BUFFER_NUM_WORDS));
   localparam cnt_t CNT_Q_LAST   = cnt_t'(OPERAND_NUM_WORDS);
   localparam cnt_t CNT_D_FIRST  = cnt_t'(D_FIRST);
   localparam cnt_t CNT_D_LAST   = cnt_t'(d_last(BUFFER_NUM_WORDS));
   localparam cnt_t CNT_E_FIRST  = cnt_t'(E_FIRST);
   localparam cnt_t CNT_E_LAST   = cnt_t'(e_last(BUFFER_NUM_WORDS));
   localparam cnt_t CNT_FLAG     = cnt_t'(flag_cnt(BUFFER_NUM_WORDS));

   cnt_t  cnt_reg, cnt_next;
   logic  sc_reg, sc_next;
   logic  q_ok_reg, q_ok_next;
   logic  borrow_reg, borrow_next;
   logic  sel_diff_reg, sel_diff_next;
   logic  k_is_nul_reg, k_is_nul_next;

   logic  rd_win, q_win, d_win, e_win;
   word_t q_masked;
   word_t sub_diff;
   logic  sub_b_in, sub_b_out;

   assign rd_win = (cnt_reg >= CNT_RD_FIRST) && (cnt_reg <= CNT_RD_LAST);
   assign q_win  = rd_win && (cnt_reg <= CNT_Q_LAST);
   assign d_win  = (cnt_reg >= CNT_D_FIRST) && (cnt_reg <= CNT_D_LAST);
   assign e_win  = (cnt_reg >= CNT_E_FIRST) && (cnt_reg <= CNT_E_LAST);

   // Pass counter: start on ena when idle, otherwise run to the flag count and wrap
   always_comb begin
      cnt_next = cnt_reg;
      if (cnt_reg == '0) begin
         if (ena) cnt_next = CNT_ONE;
      end else if (cnt_reg == CNT_FLAG) begin
         cnt_next = '0;
      end else begin
         cnt_next = cnt_reg + CNT_ONE;
      end
   end

   // Datapath next-state: carry/borrow chains clear outside their windows
   always_comb begin
      sc_next       = d_win ? s_din[31] : 1'b0;
      q_ok_next     = q_win;
      borrow_next   = e_win ? sub_b_out : 1'b0;
      sel_diff_next = (cnt_reg == CNT_FLAG) ? ~borrow_reg : sel_diff_reg;
      k_is_nul_next = (cnt_reg == CNT_RD_FIRST) ? (k == '0) : k_is_nul_reg;
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg      <= '0;
         sc_reg       <= 1'b0;
         q_ok_reg     <= 1'b0;
         borrow_reg   <= 1'b0;
         sel_diff_reg <= 1'b0;
         k_is_nul_reg <= 1'b0;
      end else begin
         cnt_reg      <= cnt_next;
         sc_reg       <= sc_next;
         q_ok_reg     <= q_ok_next;
         borrow_reg   <= borrow_next;
         sel_diff_reg <= sel_diff_next;
         k_is_nul_reg <= k_is_nul_next;
      end
   end

   // q word N-1 does not exist: zero-pad it when its read slot comes back
   assign q_masked = q_ok_reg ? q_din : '0;

   // Borrow chain starts clean on word 0
   assign sub_b_in = (cnt_reg == CNT_D_FIRST) ? 1'b0 : sub_b_out;

   subtractor32_wrapper u_sub (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (d_dout),
      .b     (q_masked),
      .b_in  (sub_b_in),
      .d     (sub_diff),
      .b_out (sub_b_out)
   );

   // Memory ports and status decode
   always_comb begin
      rdy      = (cnt_reg == '0);
      s_addr   = rd_win ? BUFFER_ADDR_BITS'(cnt_reg - CNT_RD_FIRST) : '0;
      q_addr   = q_win  ? OPERAND_ADDR_BITS'(cnt_reg - CNT_RD_FIRST) : '0;
      d_addr   = d_win  ? BUFFER_ADDR_BITS'(cnt_reg - CNT_D_FIRST) : '0;
      e_addr   = e_win  ? BUFFER_ADDR_BITS'(cnt_reg - CNT_E_FIRST) : '0;
      d_wren   = d_win;
      e_wren   = e_win;
      d_dout   = d_win ? {s_din[30:0], sc_reg} : '0;
      e_dout   = e_win ? sub_diff : '0;
      sel_diff = sel_diff_reg;
      k_is_nul = k_is_nul_reg;
   end

endmodule

// File: tb/tb_modinv_helper_double_precalc.sv
// Self-checking bench: word-level behavioural model (2*s and 2*s - q as
// 288-bit integers) against DUT writes and final memory contents.
module tb_modinv_helper_double_precalc;

   localparam int N  = 9;
   localparam int QW = 8;
   localparam logic [255:0] P256 =
      256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
   localparam logic [31:0] FILL = 32'hA5A5_5A5A;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ena;
   logic        rdy;
   logic [9:0]  k;
   logic        k_is_nul;
   logic        sel_diff;
   logic [3:0]  s_addr;
   logic [31:0] s_din;
   logic [2:0]  q_addr;
   logic [31:0] q_din;
   logic [3:0]  d_addr;
   logic        d_wren;
   logic [31:0] d_dout;
   logic [3:0]  e_addr;
   logic        e_wren;
   logic [31:0] e_dout;

   logic [31:0] s_mem [16];
   logic [31:0] q_mem [8];
   logic [31:0] d_mem [16];
   logic [31:0] e_mem [16];
   logic [31:0] d_exp [16];
   logic [31:0] e_exp [16];
   logic        sel_exp;
   logic        kn_exp;
   logic        clear_req;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   modinv_helper_double_precalc dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .rdy      (rdy),
      .k        (k),
      .k_is_nul (k_is_nul),
      .sel_diff (sel_diff),
      .s_addr   (s_addr),
      .s_din    (s_din),
      .q_addr   (q_addr),
      .q_din    (q_din),
      .d_addr   (d_addr),
      .d_wren   (d_wren),
      .d_dout   (d_dout),
      .e_addr   (e_addr),
      .e_wren   (e_wren),
      .e_dout   (e_dout)
   );

   // Block memories with one-cycle read latency
   always @(posedge clk) begin
      s_din <= s_mem[s_addr];
      q_din <= q_mem[q_addr];
      if (clear_req) begin
         for (int i = 0; i < 16; i++) begin
            d_mem[i] <= FILL;
            e_mem[i] <= FILL;
         end
      end else begin
         if (d_wren) d_mem[d_addr] <= d_dout;
         if (e_wren) e_mem[e_addr] <= e_dout;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0b, expected %0b", name, act, exp);
      end
   endtask

   // Per-cycle compare: every write against the model, idle ports quiet
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (d_wren === 1'b1) begin
            chk1("d_addr_range", d_addr < 4'(N), 1'b1);
            chk($sformatf("d_dout[%0d]", d_addr), d_dout, d_exp[d_addr]);
         end
         if (e_wren === 1'b1) begin
            chk1("e_addr_range", e_addr < 4'(N), 1'b1);
            chk($sformatf("e_dout[%0d]", e_addr), e_dout, e_exp[e_addr]);
         end
         if (rdy === 1'b1) begin
            chk1("idle_wren", d_wren | e_wren, 1'b0);
            chk("idle_addrs", {16'h0, s_addr, 1'b0, q_addr, d_addr, e_addr}, 32'h0);
         end
      end
   end

   // One pass; called and returns at a negedge with rdy=1
   task automatic do_run(input logic [287:0] s_big, input logic [255:0] q_val,
                         input logic [9:0] kv, input bit noise, input int abort_at,
                         input string tag);
      logic [287:0] q_big;
      logic [287:0] d_big;
      logic [287:0] e_big;
      int  busy;
      bit  done;
      bit  aborted;
      q_big = {32'h0, q_val};
      d_big = s_big << 1;
      e_big = d_big - q_big;
      for (int i = 0; i < N; i++) begin
         s_mem[i] = s_big[32*i +: 32];
         d_exp[i] = d_big[32*i +: 32];
         e_exp[i] = e_big[32*i +: 32];
      end
      for (int i = 0; i < QW; i++) q_mem[i] = q_big[32*i +: 32];
      sel_exp = (d_big >= q_big);
      kn_exp  = (kv == 10'd0);

      k = kv;
      ena = 1'b1;
      clear_req = 1'b1;
      @(posedge clk);
      #1;
      ena = 1'b0;
      clear_req = 1'b0;

      busy = 0;
      done = 1'b0;
      aborted = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (rdy === 1'b1) begin
            done = 1'b1;
         end else begin
            busy++;
            if (busy == 2) k = ~kv;
            ena = (noise && (busy == 3 || busy == 7)) ? 1'b1 : 1'b0;
            if (busy == abort_at) begin
               rst_n = 1'b0;
               #1;
               chk1({tag, "_abort_rdy"}, rdy, 1'b1);
               chk1({tag, "_abort_wren"}, d_wren | e_wren, 1'b0);
               chk1({tag, "_abort_sel"}, sel_diff, 1'b0);
               chk1({tag, "_abort_knul"}, k_is_nul, 1'b0);
               @(negedge clk);
               @(negedge clk);
               rst_n = 1'b1;
               aborted = 1'b1;
               done = 1'b1;
            end else if (busy > 40) begin
               n_vec++;
               n_miss++;
               $display("FAIL %s_timeout: rdy low %0d cycles, expected 12", tag, busy);
               done = 1'b1;
            end
         end
      end
      ena = 1'b0;

      if (aborted) begin
         $display("run %-12s aborted at count %0d", tag, abort_at);
      end else begin
         chk({tag, "_busy_cycles"}, 32'(busy), 32'd12);
         for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_d_mem[%0d]", tag, i), d_mem[i], d_exp[i]);
            chk($sformatf("%s_e_mem[%0d]", tag, i), e_mem[i], e_exp[i]);
         end
         chk1({tag, "_sel_diff"}, sel_diff, sel_exp);
         chk1({tag, "_k_is_nul"}, k_is_nul, kn_exp);
         $display("run %-12s busy=%0d sel_diff=%0b k_is_nul=%0b", tag, busy, sel_diff, k_is_nul);
      end
   endtask

   initial begin
      logic [287:0] rs;
      logic [255:0] rq;
      logic [9:0]   rk;
      int           mode;

      rst_n = 1'b0;
      ena = 1'b0;
      k = '0;
      clear_req = 1'b0;
      for (int i = 0; i < 16; i++) begin
         s_mem[i] = '0;
         d_exp[i] = '0;
         e_exp[i] = '0;
      end
      for (int i = 0; i < 8; i++) q_mem[i] = '0;

      repeat (3) @(negedge clk);
      chk1("reset_rdy", rdy, 1'b1);
      chk1("reset_sel", sel_diff, 1'b0);
      chk1("reset_knul", k_is_nul, 1'b0);
      chk1("reset_wren", d_wren | e_wren, 1'b0);
      chk("reset_addrs", {16'h0, s_addr, 1'b0, q_addr, d_addr, e_addr}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // s = 1: d = 2, e = 2 - q mod 2^288
      do_run(288'h1, P256, 10'd5, 1'b0, 0, "p256_s1");
      chk("pin_s1_d0", d_mem[0], 32'h0000_0002);
      chk("pin_s1_e0", e_mem[0], 32'h0000_0003);
      chk("pin_s1_e6", e_mem[6], 32'hFFFF_FFFE);
      chk("pin_s1_e8", e_mem[8], 32'hFFFF_FFFF);
      chk1("pin_s1_sel", sel_diff, 1'b0);
      repeat (2) @(negedge clk);

      // s = q - 1: d = 2q - 2, e = q - 2, take e
      do_run({32'h0, P256 - 256'd1}, P256, 10'd0, 1'b0, 0, "p256_qm1");
      chk("pin_qm1_d0", d_mem[0], 32'hFFFF_FFFC);
      chk("pin_qm1_e0", e_mem[0], 32'hFFFF_FFFD);
      chk("pin_qm1_e7", e_mem[7], 32'hFFFF_FFFF);
      chk1("pin_qm1_sel", sel_diff, 1'b1);
      repeat (2) @(negedge clk);

      // Carry across the word boundary
      do_run(288'h8000_0000, P256, 10'd9, 1'b0, 0, "cross_word");
      chk("pin_cw_d0", d_mem[0], 32'h0000_0000);
      chk("pin_cw_d1", d_mem[1], 32'h0000_0001);
      chk1("pin_cw_sel", sel_diff, 1'b0);
      repeat (2) @(negedge clk);

      // s = 0, k = 0
      do_run(288'h0, P256, 10'd0, 1'b0, 0, "zero_k0");
      chk("pin_z_e0", e_mem[0], 32'h0000_0001);
      chk("pin_z_e3", e_mem[3], 32'hFFFF_FFFF);
      chk1("pin_z_knul", k_is_nul, 1'b1);
      repeat (2) @(negedge clk);

      // ena pulses while busy, then a back-to-back restart on rdy rise
      do_run({32'h0, 256'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978}, P256, 10'd3, 1'b1, 0, "ena_noise");
      do_run({32'h0, P256 - 256'd7}, P256, 10'd1, 1'b0, 0, "back2back");

      // Flags set, then reset at count 5, then a clean run
      do_run({32'h0, P256 - 256'd1}, P256, 10'd0, 1'b0, 0, "pre_abort");
      do_run({32'h0, P256 - 256'd3}, P256, 10'd0, 1'b0, 5, "abort");
      do_run({32'h0, 256'hFFFF_0000_1111_2222}, P256, 10'd4, 1'b0, 0, "post_abort");

      // Random operands and moduli
      for (int r = 0; r < 16; r++) begin
         for (int w = 0; w < 9; w++) rs[32*w +: 32] = $urandom;
         for (int w = 0; w < 8; w++) rq[32*w +: 32] = $urandom;
         rq[255] = 1'b1;
         mode = $urandom_range(0, 2);
         if (mode == 1) rs[287:256] = 32'h0;
         if (mode == 2) rs = rs % {32'h0, rq};
         rk = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom);
         do_run(rs, rq, rk, ($urandom_range(0, 3) == 0), 0, $sformatf("rand%0d", r));
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
